// File: rtl/requant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : requant_scheduler
// Purpose  : Per-channel requantization controller. Accepts a job of N pixels,
//            each delivered as NUM_CH channel-ordered int32 accumulators, and
//            scales every beat by its channel's multiplier and right shift.
//            Results are rounded half-up and saturated to int8. Output comes
//            through a 2-stage valid/ready pipeline.
// Ports    : clk, rst                      - clock, sync active-high reset
//            cfg_we/addr/mult/shift        - per-channel table write (IDLE only)
//            start, num_pixels             - job launch (sampled in IDLE)
//            acc_valid/ready/data          - accumulator input stream
//            q_valid/ready/data/ch/last    - int8 output stream
//            busy, done                    - job status for the sequencer
// Revision : 1.0 - initial release
// ============================================================================
module requant_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int CH_IDX_W = 2,
    parameter int PIX_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_addr,
    input  logic [31:0]         cfg_mult,
    input  logic [5:0]          cfg_shift,
    input  logic                start,
    input  logic [PIX_W-1:0]    num_pixels,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [31:0]         acc_data,
    output logic                q_valid,
    input  logic                q_ready,
    output logic [7:0]          q_data,
    output logic [CH_IDX_W-1:0] q_ch,
    output logic                q_last,
    output logic                busy,
    output logic                done
);

    localparam int BEATS_W = PIX_W + CH_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BEATS_W-1:0]   beats_left_q, beats_left_d;
    logic [CH_IDX_W-1:0]  ch_q, ch_d;

    logic [31:0]          mult_q  [NUM_CH];
    logic [4:0]           shift_q [NUM_CH];

    logic                 s1_valid_q;
    logic signed [63:0]   s1_prod_q;
    logic [4:0]           s1_shift_q;
    logic [CH_IDX_W-1:0]  s1_ch_q;
    logic                 s1_last_q;

    logic                 q_valid_q;
    logic [7:0]           q_data_q;
    logic [CH_IDX_W-1:0]  q_ch_q;
    logic                 q_last_q;

    logic                 w_en;
    logic                 w_accept;
    logic [BEATS_W-1:0]   w_job_beats;
    logic [4:0]           w_cfg_shift;
    logic [31:0]          w_mult_sel;
    logic signed [63:0]   w_prod;
    logic signed [63:0]   w_bias;
    logic signed [63:0]   w_round;
    logic [7:0]           w_sat;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign w_en      = !q_valid_q || q_ready;
    assign acc_ready = (state_q == S_RUN) && w_en;
    assign w_accept  = acc_valid && acc_ready;

    assign w_job_beats = BEATS_W'(num_pixels) * BEATS_W'(NUM_CH);
    assign w_cfg_shift = cfg_shift[5] ? 5'd31 : cfg_shift[4:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        ch_d         = ch_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_d = '0;
                    if (num_pixels != '0) begin
                        beats_left_d = w_job_beats;
                        state_d      = S_RUN;
                    end else begin
                        state_d      = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    beats_left_d = beats_left_q - BEATS_W'(1);
                    ch_d = (ch_q == CH_IDX_W'(NUM_CH - 1)) ? '0 : ch_q + CH_IDX_W'(1);
                    if (beats_left_q == BEATS_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q && !q_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beats_left_q <= '0;
            ch_q         <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            ch_q         <= ch_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Per-channel table; reset restores identity scaling (mult=1, shift=0)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mult_q[i]  <= 32'd1;
                shift_q[i] <= 5'd0;
            end
        end else if (cfg_we && (state_q == S_IDLE)) begin
            mult_q[cfg_addr]  <= cfg_mult;
            shift_q[cfg_addr] <= w_cfg_shift;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: full-precision signed product
    // ------------------------------------------------------------------
    assign w_mult_sel = mult_q[ch_q];
    assign w_prod     = 64'($signed(acc_data)) * 64'($signed(w_mult_sel));

    // ------------------------------------------------------------------
    // Stage 2: round half up, arithmetic shift, saturate to int8.
    // |product| <= 2^62, so adding the 2^30 max bias cannot overflow 64 bits.
    // ------------------------------------------------------------------
    assign w_bias  = (s1_shift_q == 5'd0) ? 64'sd0 : (64'sd1 <<< (s1_shift_q - 5'd1));
    assign w_round = (s1_prod_q + w_bias) >>> s1_shift_q;

    always_comb begin
        w_sat = w_round[7:0];
        if (w_round > 64'sd127) begin
            w_sat = 8'h7F;
        end else if (w_round < -64'sd128) begin
            w_sat = 8'h80;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_shift_q <= '0;
            s1_ch_q    <= '0;
            s1_last_q  <= 1'b0;
            q_valid_q  <= 1'b0;
            q_data_q   <= '0;
            q_ch_q     <= '0;
            q_last_q   <= 1'b0;
        end else if (w_en) begin
            s1_valid_q <= w_accept;
            if (w_accept) begin
                s1_prod_q  <= w_prod;
                s1_shift_q <= shift_q[ch_q];
                s1_ch_q    <= ch_q;
                s1_last_q  <= (beats_left_q == BEATS_W'(1));
            end
            q_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                q_data_q <= w_sat;
                q_ch_q   <= s1_ch_q;
                q_last_q <= s1_last_q;
            end
        end
    end

    assign q_valid = q_valid_q;
    assign q_data  = q_data_q;
    assign q_ch    = q_ch_q;
    assign q_last  = q_last_q;

endmodule
`default_nettype wire

// File: tb/tb_requant_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_requant_scheduler
// Purpose  : Self-checking bench for requant_scheduler. A reference model of
//            the channel table predicts each output at the moment its input
//            beat is accepted; outputs are popped and compared on handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_requant_scheduler;

    localparam int NUM_CH   = 4;
    localparam int CH_IDX_W = 2;
    localparam int PIX_W    = 16;

    logic                clk;
    logic                rst;
    logic                cfg_we;
    logic [CH_IDX_W-1:0] cfg_addr;
    logic [31:0]         cfg_mult;
    logic [5:0]          cfg_shift;
    logic                start;
    logic [PIX_W-1:0]    num_pixels;
    logic                acc_valid;
    logic                acc_ready;
    logic [31:0]         acc_data;
    logic                q_valid;
    logic                q_ready;
    logic [7:0]          q_data;
    logic [CH_IDX_W-1:0] q_ch;
    logic                q_last;
    logic                busy;
    logic                done;

    requant_scheduler #(
        .NUM_CH  (NUM_CH),
        .CH_IDX_W(CH_IDX_W),
        .PIX_W   (PIX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .start     (start),
        .num_pixels(num_pixels),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_data    (q_data),
        .q_ch      (q_ch),
        .q_last    (q_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
        logic       last;
    } exp_t;

    int   n_checks;
    int   n_errors;
    int   tb_mult  [NUM_CH];
    int   tb_shift [NUM_CH];
    exp_t sb [$];
    int   stim [$];

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            tb_mult[i]  = 1;
            tb_shift[i] = 0;
        end
    endtask

    function automatic logic [7:0] model(input int acc, input int ch);
        longint p;
        longint r;
        int     s;
        s = tb_shift[ch];
        p = longint'(acc) * longint'(tb_mult[ch]);
        if (s == 0) r = p;
        else        r = (p + (longint'(1) << (s - 1))) >>> s;
        if (r > 127)       return 8'h7F;
        else if (r < -128) return 8'h80;
        else               return r[7:0];
    endfunction

    task automatic load4(input int a, input int b, input int c, input int d);
        stim.push_back(a);
        stim.push_back(b);
        stim.push_back(c);
        stim.push_back(d);
    endtask

    // Single-cycle table write; the model follows only when the DUT should.
    task automatic write_cfg(input int ch, input int m, input int s, input bit upd);
        cfg_we    = 1'b1;
        cfg_addr  = CH_IDX_W'(ch);
        cfg_mult  = m;
        cfg_shift = 6'(s);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (upd) begin
            tb_mult[ch]  = m;
            tb_shift[ch] = (s > 31) ? 31 : s;
        end
    endtask

    // Launch a job over stim[], scoreboard every beat, optionally stall the
    // output after a given output count, optionally poke cfg/start mid-job,
    // then check the DRAIN -> DONE -> IDLE tail. Entered/left at posedge+1.
    task automatic drive_job(input string name, input int npix,
                             input int stall_after, input int stall_len,
                             input bit inject);
        int   total;
        int   bi;
        int   oi;
        int   stall_left;
        int   cyc;
        bit   held_v;
        exp_t held;
        exp_t e;
        exp_t got;
        total = npix * NUM_CH;
        bi = 0; oi = 0; stall_left = 0; cyc = 0; held_v = 1'b0; held = '0;
        start      = 1'b1;
        num_pixels = PIX_W'(npix);
        @(posedge clk); #1;
        start = 1'b0;
        while (oi < total && cyc < 400) begin
            acc_valid = (bi < total);
            acc_data  = (bi < total) ? stim[bi] : 32'd0;
            q_ready   = (stall_left == 0);
            if (inject && bi == 2) begin
                cfg_we = 1'b1; cfg_addr = '0; cfg_mult = 32'd2; cfg_shift = 6'd0;
                start  = 1'b1; num_pixels = PIX_W'(5);
            end else begin
                cfg_we = 1'b0;
                start  = 1'b0;
            end
            @(negedge clk);
            got = {q_data, q_ch[1:0], q_last};
            if (held_v) begin
                n_checks++;
                if (q_valid !== 1'b1 || got !== held) begin
                    n_errors++;
                    $display("FAIL %s stall_hold: got v=%0b %h, want v=1 %h", name, q_valid, got, held);
                end
            end
            if (!q_ready && q_valid) begin
                n_checks++;
                if (acc_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s stall_acc_ready: got %0b, want 0", name, acc_ready);
                end
            end
            held_v = q_valid && !q_ready;
            held   = got;
            if (!q_ready) stall_left--;
            if (q_valid && q_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s unexpected_output: got d=%0d ch=%0d last=%0b, want none",
                             name, $signed(q_data), q_ch, q_last);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_errors++;
                        $display("FAIL %s out%0d: got d=%0d ch=%0d last=%0b, want d=%0d ch=%0d last=%0b",
                                 name, oi, $signed(q_data), q_ch, q_last, $signed(e.d), e.ch, e.last);
                    end
                end
                oi++;
                if (oi == stall_after) stall_left = stall_len;
            end
            if (acc_valid && acc_ready) begin
                e.d    = model(stim[bi], bi % NUM_CH);
                e.ch   = 2'(bi % NUM_CH);
                e.last = (bi == total - 1);
                sb.push_back(e);
                bi++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        acc_valid = 1'b0; cfg_we = 1'b0; start = 1'b0; q_ready = 1'b1;
        n_checks++;
        if (oi != total) begin
            n_errors++;
            $display("FAIL %s timeout: got %0d outputs, want %0d", name, oi, total);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s drain: got done=%0b busy=%0b, want done=0 busy=1", name, done, busy);
        end
        @(posedge clk); #1; @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_pulse: got done=%0b busy=%0b, want done=1 busy=1", name, done, busy);
        end
        @(posedge clk); #1; @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s idle_after: got done=%0b busy=%0b pending=%0d, want 0 0 0",
                     name, done, busy, sb.size());
        end
        @(posedge clk); #1;
        stim.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({acc_ready, q_valid, q_data, q_ch, q_last, busy, done} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ar=%0b qv=%0b qd=%0d qch=%0d ql=%0b busy=%0b done=%0b, want all 0",
                     acc_ready, q_valid, q_data, q_ch, q_last, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_identity();
        load4(100, 200, -200, 5);
        drive_job("identity", 1, -1, 0, 1'b0);
    endtask

    task automatic test_scaling();
        write_cfg(1, 3, 2, 1'b1);
        load4(0, 5, 0, 0);
        load4(0, -5, 0, 0);
        load4(0, 6, 0, 0);
        drive_job("scale_ch1", 3, -1, 0, 1'b0);
        write_cfg(2, 32'h7FFF_FFFF, 31, 1'b1);
        write_cfg(3, 32'h4000_0000, 40, 1'b1);
        load4(-7, 9, 3, 4);
        drive_job("scale_big", 1, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        model_reset();
        write_cfg(1, 1, 0, 1'b1);
        write_cfg(2, 1, 0, 1'b1);
        write_cfg(3, 1, 0, 1'b1);
        load4(1, -2, 3, -4);
        load4(50, -60, 70, -80);
        drive_job("stall", 2, 3, 5, 1'b0);
    endtask

    task automatic test_busy_cfg_ignored();
        load4(10, 20, 30, 40);
        load4(11, 21, 31, 41);
        drive_job("cfg_in_run", 2, -1, 0, 1'b1);
        write_cfg(0, 2, 0, 1'b1);
        write_cfg(1, 3, 2, 1'b1);
        load4(10, 20, 30, 40);
        drive_job("cfg_after", 1, -1, 0, 1'b0);
    endtask

    task automatic test_zero_pixels();
        start      = 1'b1;
        num_pixels = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || acc_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_pre: got busy=%0b ar=%0b, want 0 0", busy, acc_ready);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b1 || acc_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_done: got busy=%0b done=%0b ar=%0b, want 1 1 0", busy, done, acc_ready);
        end
        @(posedge clk); #1; @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || acc_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_idle: got busy=%0b done=%0b ar=%0b, want 0 0 0", busy, done, acc_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int acc_cnt;
        int cyc;
        acc_cnt    = 0;
        cyc        = 0;
        start      = 1'b1;
        num_pixels = PIX_W'(2);
        @(posedge clk); #1;
        start     = 1'b0;
        q_ready   = 1'b1;
        acc_valid = 1'b1;
        acc_data  = 32'd10;
        while (acc_cnt < 3 && cyc < 50) begin
            @(negedge clk);
            if (acc_valid && acc_ready) acc_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (acc_cnt != 3) begin
            n_errors++;
            $display("FAIL midrst_accepts: got %0d, want 3", acc_cnt);
        end
        acc_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0 || acc_ready !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_state: got qv=%0b busy=%0b ar=%0b done=%0b, want all 0",
                     q_valid, busy, acc_ready, done);
        end
        @(posedge clk); #1;
        sb.delete();
        model_reset();
        load4(50, 5, -7, 3);
        drive_job("after_rst", 1, -1, 0, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_mult   = '0;
        cfg_shift  = '0;
        start      = 1'b0;
        num_pixels = '0;
        acc_valid  = 1'b0;
        acc_data   = '0;
        q_ready    = 1'b1;
        model_reset();
        test_reset();
        test_identity();
        test_scaling();
        test_backpressure();
        test_busy_cfg_ignored();
        test_zero_pixels();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/requant_scheduler.md
Name: requant_scheduler

Overview:
Per-channel requantization controller for the conv/FC output path. It accepts a job of N pixels, each delivered as NUM_CH channel-ordered int32 accumulators. Each beat is tagged with its channel index and scaled by that channel's programmable multiplier and shift, then rounded and saturated to int8. Output uses a 2-stage pipeline with valid/ready backpressure, plus job start/busy/done control for the layer sequencer.

Parameters:
NUM_CH, 4, channels per pixel; channel index wraps at NUM_CH-1
CH_IDX_W, 2, width of channel index (clog2 NUM_CH, min 1)
PIX_W, 16, width of the pixel count

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  write one entry of the per-channel table
cfg_addr  in  CH_IDX_W  channel entry to write
cfg_mult  in  32  signed multiplier
cfg_shift  in  6  right shift; values >31 stored as 31
start  in  1  job start pulse; sampled only in IDLE
num_pixels  in  PIX_W  pixels in the job; sampled with start
acc_valid  in  1  accumulator beat valid
acc_ready  out  1  accumulator beat accepted when valid&ready
acc_data  in  32  signed accumulator
q_valid  out  1  output beat valid
q_ready  in  1  downstream ready
q_data  out  8  signed saturated result
q_ch  out  CH_IDX_W  channel index of q_data
q_last  out  1  final beat of the job
busy  out  1  high in any state other than IDLE
done  out  1  single-cycle job-complete pulse

Behaviour:
- Reset: state IDLE; all table entries mult=1, shift=0; ch/pixel counters 0; every pipeline valid 0.
- Reset outputs: acc_ready=0, q_valid=0, q_data=0, q_ch=0, q_last=0, busy=0, done=0.
- States:
  - IDLE: start&&num_pixels!=0 loads beats_left=num_pixels*NUM_CH, goes to RUN. start&&num_pixels==0 goes to DONE. Other start conditions ignored.
  - RUN: accepts beats. The accept that drops beats_left to 0 moves the FSM to DRAIN.
  - DRAIN: no accepts. Stays until both pipeline stages are empty, then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Table writes: cfg_we honoured only in IDLE. Writes in any other state are dropped.
- Stall enable: en = !q_valid || q_ready. All stages advance only when en=1.
- acc_ready = (state==RUN) && en. This is combinational.
- Accept: per accepted beat the channel counter increments and wraps NUM_CH-1 -> 0. Beat k of the job carries ch = k mod NUM_CH.
- Stage 1: on accept, register product = acc_data * mult[ch] as a full signed 64-bit value. Also register shift[ch], ch, and last = (beats_left==1).
- Stage 2: compute r = s==0 ? product : (product + (1<<<(s-1))) >>> s, using an arithmetic shift (round half up).
  - r > 127 -> 127; r < -128 -> -128; otherwise r[7:0].
  - Register the result into q_data/q_ch/q_last.
- Latency: 2 cycles from accept to q_valid when unstalled. Throughput is 1 beat/cycle.
- Stall hold: while q_valid&&!q_ready, q_data/q_ch/q_last hold stable. Nothing is lost or duplicated.
- q_last=1 only on the final beat of the job.
- DONE is entered the cycle after the q_last handshake (DRAIN sees an empty pipeline).
- num_pixels*NUM_CH is computed at PIX_W+CH_IDX_W bits, with no overflow.
- Mid-job rst: the cycle after rst, everything is at reset values. In-flight beats are discarded and the table returns to identity.

Test Plan:
1. Identity table, start num_pixels=1, acc=100,200,-200,5, q_ready=1 -> q_data 100,127,-128,5; q_ch 0..3; q_last on 4th only; done one cycle after the 4th handshake.
2. Write ch1 mult=3 shift=2 in IDLE. Send acc 5,-5,6 on ch1 across three pixels (others 0) -> ch1 outputs 4,-4,5. Write ch2 mult=0x7FFFFFFF shift=31, acc=3 -> 3.
3. num_pixels=2, q_ready held 0 for 5 cycles after the 3rd output -> acc_ready=0 while stalled; q_data stable; 8 outputs total in order; q_ch 0,1,2,3,0,1,2,3; q_last only on 8th.
4. During RUN, pulse cfg_we ch0 mult=2 and start -> table unchanged and job unaffected. After done, the same write takes effect on the next job.
5. start with num_pixels=0 -> busy=1 for one cycle, done=1 that same cycle, acc_ready never 1, back to IDLE.
6. Assert rst after 3 accepts of a 2-pixel job -> next cycle q_valid=0, busy=0, acc_ready=0, table identity. A fresh start num_pixels=1 completes normally.
